// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: draw coordinates, blank qualifier, active-low syncs.
// Optional VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame_count animation time base.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_S = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_S  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BACK_S  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_S = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_S  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BACK_S  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

    region_t     h_state, h_state_nxt, v_state, v_state_nxt;
    logic [9:0]  h_nxt, v_nxt;
    logic        h_wrap, v_wrap;

    always_comb begin
        h_wrap = (DrawX == H_LAST);
        v_wrap = h_wrap && (DrawY == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : DrawX + 10'd1;
        if (v_wrap)      v_nxt = 10'd0;
        else if (h_wrap) v_nxt = DrawY + 10'd1;
        else             v_nxt = DrawY;

        h_state_nxt = h_state;
        case (h_state)
            ACTIVE:  if (h_nxt == H_FRONT_S) h_state_nxt = FRONT;
            FRONT:   if (h_nxt == H_SYNC_S)  h_state_nxt = SYNC;
            SYNC:    if (h_nxt == H_BACK_S)  h_state_nxt = BACK;
            default: if (h_nxt == 10'd0)     h_state_nxt = ACTIVE;
        endcase

        // Vertical regions only move on the line boundary.
        v_state_nxt = v_state;
        if (h_wrap) begin
            case (v_state)
                ACTIVE:  if (v_nxt == V_FRONT_S) v_state_nxt = FRONT;
                FRONT:   if (v_nxt == V_SYNC_S)  v_state_nxt = SYNC;
                SYNC:    if (v_nxt == V_BACK_S)  v_state_nxt = BACK;
                default: if (v_nxt == 10'd0)     v_state_nxt = ACTIVE;
            endcase
        end
    end

    // Outputs decode the next-state values so they line up with the new DrawX/DrawY.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            h_state     <= ACTIVE;
            v_state     <= ACTIVE;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= h_nxt;
            DrawY       <= v_nxt;
            h_state     <= h_state_nxt;
            v_state     <= v_state_nxt;
            hs          <= (h_state_nxt != SYNC);
            vs          <= (v_state_nxt != SYNC);
            blank       <= (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
            line_start  <= (h_nxt == 10'd0);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)    frame_count <= '0;
        else if (v_wrap) frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
